// File: rtl/udt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// udt_ctrl_pkg
// Shared definitions for the UDT control path:
//   - close_state_t : state encoding for the connection-teardown sequencer
//   - CTRL_*        : UDT control packet type codes
//   - CTRL_*_BIT/MSB/LSB : bit positions inside the 64-bit control header word
//   - TIMER_W_DEFAULT    : default linger counter width
//   - ctrl_header() : builds a control header word for a given type code
// -----------------------------------------------------------------------------
package udt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_SEND_SHUT = 3'd3,
        ST_WAIT_REV  = 3'd4,
        ST_CLOSED    = 3'd5
    } close_state_t;

    // UDT control packet types (15-bit type field)
    localparam logic [14:0] CTRL_HANDSHAKE  = 15'h0000;
    localparam logic [14:0] CTRL_KEEPALIVE  = 15'h0001;
    localparam logic [14:0] CTRL_ACK        = 15'h0002;
    localparam logic [14:0] CTRL_NAK        = 15'h0003;
    localparam logic [14:0] CTRL_CONGESTION = 15'h0004;
    localparam logic [14:0] CTRL_SHUTDOWN   = 15'h0005;
    localparam logic [14:0] CTRL_ACK2       = 15'h0006;
    localparam logic [14:0] CTRL_DROPREQ    = 15'h0007;

    // Control header layout: bit 63 flags a control packet, bits 62:48 carry
    // the type, bits 47:32 the extended type, bits 31:0 additional info.
    localparam int CTRL_FLAG_BIT = 63;
    localparam int CTRL_TYPE_MSB = 62;
    localparam int CTRL_TYPE_LSB = 48;

    localparam int TIMER_W_DEFAULT = 24;

    function automatic logic [63:0] ctrl_header(input logic [14:0] ctrl_type);
        logic [63:0] word;
        word = '0;
        word[CTRL_FLAG_BIT] = 1'b1;
        word[CTRL_TYPE_MSB:CTRL_TYPE_LSB] = ctrl_type;
        return word;
    endfunction

endpackage

// File: rtl/udt_linger_timer.sv
// -----------------------------------------------------------------------------
// udt_linger_timer
// Saturating tick counter bounding how long the close sequencer waits for the
// send buffer to drain. Built only when UDT_CLOSE_LINGER_EN is defined.
// Ports:
//   core_clk, core_rst_n : clock, asynchronous active-low reset
//   tick_i    : one-cycle timebase pulse; counter advances by one per pulse
//   clear_i   : synchronous clear (takes priority over tick_i)
//   expired_o : combinational; high when tick_i arrives with the count already
//               at LIMIT-1, i.e. this tick is the LIMIT-th one
// Parameters: TIMER_W (counter width), LIMIT (ticks until expiry, >= 1)
// -----------------------------------------------------------------------------
`ifdef UDT_CLOSE_LINGER_EN
module udt_linger_timer
    import udt_ctrl_pkg::*;
#(
    parameter int TIMER_W = TIMER_W_DEFAULT,
    parameter int LIMIT   = 180000
) (
    input  logic core_clk,
    input  logic core_rst_n,
    input  logic tick_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LAST      = TIMER_W'(LIMIT - 1);
    localparam logic [TIMER_W-1:0] COUNT_MAX = '1;

    logic [TIMER_W-1:0] count_q;

    // Saturates at all-ones so a missed clear can never wrap back to zero.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (tick_i && (count_q != COUNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = tick_i && (count_q >= LAST);

endmodule
`endif

// File: rtl/udt_close_sequencer.sv
// -----------------------------------------------------------------------------
// udt_close_sequencer
// Sequences UDT connection teardown: consumes the CLOSE control stream, freezes
// application sends, waits for the send buffer to drain, emits one SHUTDOWN
// control word, then waits for the receive buffer to empty and reports closed.
//
// Configuration macro: UDT_CLOSE_LINGER_EN
//   defined   - linger timer bounds the send-buffer drain; linger_expired_o
//               reports a timeout exit.
//   undefined - drain waits indefinitely; tick_i ignored, linger_expired_o = 0.
//
// Ports:
//   core_clk, core_rst_n    : clock, asynchronous active-low reset
//   tick_i                  : linger timebase pulse
//   close_t*                : CLOSE AXI-stream in (data/keep ignored)
//   SND_BUFFER_EMPTY_i      : send buffer empty
//   REV_BUFFER_EMPTY_i      : receive buffer empty
//   snd_stop_o              : block new application data
//   shut_t*                 : SHUTDOWN AXI-stream out (single-beat packet)
//   closed_o                : connection closed, sticky until reset
//   linger_expired_o        : drain ended by timeout, sticky until reset
//
// All control outputs are registered: they are decoded from the next state
// and loaded together with the state register, so each output reflects the
// state the sequencer is currently in without an extra cycle of lag.
// -----------------------------------------------------------------------------
module udt_close_sequencer
    import udt_ctrl_pkg::*;
#(
    parameter int          TIMER_W      = TIMER_W_DEFAULT,
    parameter int          LINGER_TICKS = 180000,
    parameter logic [14:0] SHUT_TYPE    = CTRL_SHUTDOWN
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        tick_i,
    input  logic        close_tvalid_i,
    input  logic [63:0] close_tdata_i,
    input  logic [7:0]  close_tkeep_i,
    input  logic        close_tlast_i,
    output logic        close_tready_o,
    input  logic        SND_BUFFER_EMPTY_i,
    input  logic        REV_BUFFER_EMPTY_i,
    output logic        snd_stop_o,
    output logic        shut_tvalid_o,
    output logic [63:0] shut_tdata_o,
    output logic [7:0]  shut_tkeep_o,
    output logic        shut_tlast_o,
    input  logic        shut_tready_i,
    output logic        closed_o,
    output logic        linger_expired_o
);

    localparam logic [63:0] SHUT_WORD = ctrl_header(SHUT_TYPE);

    close_state_t state_q, state_d;

    logic close_accept;
    logic shut_accept;
    logic linger_hit;
    logic close_ready_d;
    logic snd_stop_d;
    logic shut_valid_d;
    logic closed_d;

    // CLOSE payload carries nothing the sequencer needs.
    logic unused_close_payload;
    assign unused_close_payload = ^{close_tdata_i, close_tkeep_i};

    assign close_accept = close_tvalid_i && close_tready_o;
    assign shut_accept  = shut_tvalid_o && shut_tready_i;

    // NOTE: every signal is given a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (close_accept) begin
                    state_d = close_tlast_i ? ST_FLUSH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (close_accept && close_tlast_i) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Empty buffer and timer expiry both leave; the empty case is
                // distinguished only in the sticky linger flag below.
                if (SND_BUFFER_EMPTY_i || linger_hit) begin
                    state_d = ST_SEND_SHUT;
                end
            end
            ST_SEND_SHUT: begin
                if (shut_accept) begin
                    state_d = ST_WAIT_REV;
                end
            end
            ST_WAIT_REV: begin
                if (REV_BUFFER_EMPTY_i) begin
                    state_d = ST_CLOSED;
                end
            end
            ST_CLOSED: begin
                state_d = ST_CLOSED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // CLOSED keeps tready high so late CLOSE beats are swallowed.
        close_ready_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN) ||
                        (state_d == ST_CLOSED);
        snd_stop_d    = (state_d == ST_FLUSH) || (state_d == ST_SEND_SHUT) ||
                        (state_d == ST_WAIT_REV) || (state_d == ST_CLOSED);
        shut_valid_d  = (state_d == ST_SEND_SHUT);
        closed_d      = (state_d == ST_CLOSED);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q        <= ST_IDLE;
            close_tready_o <= 1'b0;
            snd_stop_o     <= 1'b0;
            shut_tvalid_o  <= 1'b0;
            closed_o       <= 1'b0;
        end else begin
            state_q        <= state_d;
            close_tready_o <= close_ready_d;
            snd_stop_o     <= snd_stop_d;
            shut_tvalid_o  <= shut_valid_d;
            closed_o       <= closed_d;
        end
    end

    // The header is a constant; gating it with valid keeps the bus at zero
    // outside SEND_SHUT and in reset.
    assign shut_tdata_o = shut_tvalid_o ? SHUT_WORD : 64'h0;
    assign shut_tkeep_o = 8'hFF;
    assign shut_tlast_o = shut_tvalid_o;

`ifdef UDT_CLOSE_LINGER_EN
    logic linger_set;

    // Clear whenever the sequencer will not be in FLUSH next cycle, so the
    // count always starts from zero on FLUSH entry.
    udt_linger_timer #(
        .TIMER_W (TIMER_W),
        .LIMIT   (LINGER_TICKS)
    ) u_linger_timer (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .tick_i     (tick_i),
        .clear_i    (state_d != ST_FLUSH),
        .expired_o  (linger_hit)
    );

    assign linger_set = (state_q == ST_FLUSH) && !SND_BUFFER_EMPTY_i && linger_hit;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            linger_expired_o <= 1'b0;
        end else if (linger_set) begin
            linger_expired_o <= 1'b1;
        end
    end
`else
    logic unused_tick;
    assign unused_tick      = tick_i;
    assign linger_hit       = 1'b0;
    assign linger_expired_o = 1'b0;
`endif

endmodule

// File: tb/tb_udt_close_sequencer.sv
// -----------------------------------------------------------------------------
// tb_udt_close_sequencer
// Directed bench for udt_close_sequencer with LINGER_TICKS = 4. Outputs are
// sampled 1 ns after each rising edge; inputs are driven at the same point.
// Control outputs are compared as one vector:
//   {close_tready_o, snd_stop_o, shut_tvalid_o, closed_o, linger_expired_o}
// -----------------------------------------------------------------------------
module tb_udt_close_sequencer;

    localparam int          TIMER_W      = 24;
    localparam int          LINGER_TICKS = 4;
    localparam logic [63:0] SHUT_WORD    = 64'h8005_0000_0000_0000;

    // Expected control-output vectors {ready, stop, valid, closed, linger}
    localparam logic [4:0] O_RESET  = 5'b00000;
    localparam logic [4:0] O_IDLE   = 5'b10000;
    localparam logic [4:0] O_FLUSH  = 5'b01000;
    localparam logic [4:0] O_SEND   = 5'b01100;
    localparam logic [4:0] O_WAIT   = 5'b01000;
    localparam logic [4:0] O_CLOSED = 5'b11010;

    logic        core_clk = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        tick_i = 1'b0;
    logic        close_tvalid_i = 1'b0;
    logic [63:0] close_tdata_i = 64'h0;
    logic [7:0]  close_tkeep_i = 8'hFF;
    logic        close_tlast_i = 1'b0;
    logic        close_tready_o;
    logic        SND_BUFFER_EMPTY_i = 1'b0;
    logic        REV_BUFFER_EMPTY_i = 1'b0;
    logic        snd_stop_o;
    logic        shut_tvalid_o;
    logic [63:0] shut_tdata_o;
    logic [7:0]  shut_tkeep_o;
    logic        shut_tlast_o;
    logic        shut_tready_i = 1'b0;
    logic        closed_o;
    logic        linger_expired_o;

    int vectors = 0;
    int miscompares = 0;
    int handshakes = 0;

    logic [4:0] obs;
    assign obs = {close_tready_o, snd_stop_o, shut_tvalid_o, closed_o, linger_expired_o};

    udt_close_sequencer #(
        .TIMER_W      (TIMER_W),
        .LINGER_TICKS (LINGER_TICKS),
        .SHUT_TYPE    (15'h0005)
    ) dut (
        .core_clk           (core_clk),
        .core_rst_n         (core_rst_n),
        .tick_i             (tick_i),
        .close_tvalid_i     (close_tvalid_i),
        .close_tdata_i      (close_tdata_i),
        .close_tkeep_i      (close_tkeep_i),
        .close_tlast_i      (close_tlast_i),
        .close_tready_o     (close_tready_o),
        .SND_BUFFER_EMPTY_i (SND_BUFFER_EMPTY_i),
        .REV_BUFFER_EMPTY_i (REV_BUFFER_EMPTY_i),
        .snd_stop_o         (snd_stop_o),
        .shut_tvalid_o      (shut_tvalid_o),
        .shut_tdata_o       (shut_tdata_o),
        .shut_tkeep_o       (shut_tkeep_o),
        .shut_tlast_o       (shut_tlast_o),
        .shut_tready_i      (shut_tready_i),
        .closed_o           (closed_o),
        .linger_expired_o   (linger_expired_o)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) begin
        if (core_rst_n && shut_tvalid_o && shut_tready_i) handshakes++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic idle_inputs();
        tick_i = 1'b0;
        close_tvalid_i = 1'b0;
        close_tlast_i = 1'b0;
        close_tdata_i = 64'h0;
        SND_BUFFER_EMPTY_i = 1'b0;
        REV_BUFFER_EMPTY_i = 1'b0;
        shut_tready_i = 1'b0;
    endtask

    // Applies reset, checks reset values, releases and checks IDLE.
    task automatic test_reset();
        core_rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        vectors++;
        if (obs !== O_RESET) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", obs, O_RESET);
        end
        vectors++;
        if (shut_tkeep_o !== 8'hFF || shut_tdata_o !== 64'h0 || shut_tlast_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_shut_bus: got keep=%h data=%h last=%b want keep=ff data=0 last=0",
                     shut_tkeep_o, shut_tdata_o, shut_tlast_o);
        end
        core_rst_n = 1'b1;
        step();
        vectors++;
        if (obs !== O_IDLE) begin
            miscompares++;
            $display("FAIL reset_to_idle: got %b want %b", obs, O_IDLE);
        end
    endtask

    // Single tlast beat, both buffers empty, generator always ready.
    task automatic test_single_beat();
        logic [4:0] exp_seq [4];
        int hs_start;
        exp_seq = '{O_FLUSH, O_SEND, O_WAIT, O_CLOSED};
        test_reset();
        SND_BUFFER_EMPTY_i = 1'b1;
        REV_BUFFER_EMPTY_i = 1'b1;
        shut_tready_i = 1'b1;
        close_tvalid_i = 1'b1;
        close_tlast_i = 1'b1;
        close_tdata_i = 64'hDEAD_BEEF_0000_0001;
        hs_start = handshakes;
        for (int c = 0; c < 4; c++) begin
            step();
            close_tvalid_i = 1'b0;
            close_tlast_i = 1'b0;
            vectors++;
            if (obs !== exp_seq[c]) begin
                miscompares++;
                $display("FAIL single_cycle%0d: got %b want %b", c + 1, obs, exp_seq[c]);
            end
            if (c == 1) begin
                vectors++;
                if (shut_tdata_o !== SHUT_WORD || shut_tlast_o !== 1'b1 || shut_tkeep_o !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL single_header: got data=%h last=%b keep=%h want data=%h last=1 keep=ff",
                             shut_tdata_o, shut_tlast_o, shut_tkeep_o, SHUT_WORD);
                end
            end
        end
        vectors++;
        if (handshakes - hs_start !== 1) begin
            miscompares++;
            $display("FAIL single_handshakes: got %0d want 1", handshakes - hs_start);
        end
        // Late CLOSE beats in CLOSED are swallowed without leaving CLOSED.
        close_tvalid_i = 1'b1;
        close_tlast_i = 1'b1;
        step();
        step();
        close_tvalid_i = 1'b0;
        close_tlast_i = 1'b0;
        vectors++;
        if (obs !== O_CLOSED) begin
            miscompares++;
            $display("FAIL closed_sticky: got %b want %b", obs, O_CLOSED);
        end
    endtask

    // Three-beat CLOSE with gaps, generator stalled 20 cycles, then reset in
    // WAIT_REV.
    task automatic test_multi_beat_stall();
        logic [1:0] beats [6];   // {tvalid, tlast} per cycle
        int hs_start;
        beats = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
        test_reset();
        SND_BUFFER_EMPTY_i = 1'b1;
        REV_BUFFER_EMPTY_i = 1'b0;
        shut_tready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            close_tvalid_i = beats[c][1];
            close_tlast_i = beats[c][0];
            step();
            close_tvalid_i = 1'b0;
            close_tlast_i = 1'b0;
            vectors++;
            if (c < 5 && obs !== O_IDLE) begin
                miscompares++;
                $display("FAIL drain_cycle%0d: got %b want %b", c, obs, O_IDLE);
            end else if (c == 5 && obs !== O_FLUSH) begin
                miscompares++;
                $display("FAIL drain_to_flush: got %b want %b", obs, O_FLUSH);
            end
        end
        hs_start = handshakes;
        for (int c = 0; c < 20; c++) begin
            step();
            vectors++;
            if (obs !== O_SEND || shut_tdata_o !== SHUT_WORD) begin
                miscompares++;
                $display("FAIL stall_cycle%0d: got %b data=%h want %b data=%h",
                         c, obs, shut_tdata_o, O_SEND, SHUT_WORD);
            end
        end
        shut_tready_i = 1'b1;
        step();
        vectors++;
        if (obs !== O_WAIT) begin
            miscompares++;
            $display("FAIL stall_release: got %b want %b", obs, O_WAIT);
        end
        step();
        step();
        vectors++;
        if (obs !== O_WAIT || handshakes - hs_start !== 1) begin
            miscompares++;
            $display("FAIL wait_rev_hold: got %b hs=%0d want %b hs=1",
                     obs, handshakes - hs_start, O_WAIT);
        end
        // Asynchronous reset in WAIT_REV, checked before any clock edge.
        @(negedge core_clk);
        core_rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== O_RESET || shut_tkeep_o !== 8'hFF || shut_tdata_o !== 64'h0) begin
            miscompares++;
            $display("FAIL midop_reset: got %b keep=%h data=%h want %b keep=ff data=0",
                     obs, shut_tkeep_o, shut_tdata_o, O_RESET);
        end
        idle_inputs();
        step();
        core_rst_n = 1'b1;
        step();
        vectors++;
        if (obs !== O_IDLE) begin
            miscompares++;
            $display("FAIL midop_reset_idle: got %b want %b", obs, O_IDLE);
        end
    endtask

`ifdef UDT_CLOSE_LINGER_EN
    // Send buffer never empties; 4th tick (10-cycle spacing) forces SHUTDOWN.
    task automatic test_linger_timeout();
        test_reset();
        SND_BUFFER_EMPTY_i = 1'b0;
        REV_BUFFER_EMPTY_i = 1'b1;
        shut_tready_i = 1'b1;
        close_tvalid_i = 1'b1;
        close_tlast_i = 1'b1;
        step();
        close_tvalid_i = 1'b0;
        close_tlast_i = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick_i = 1'b1;
            step();
            tick_i = 1'b0;
            if (t < 4) begin
                for (int c = 0; c < 9; c++) begin
                    vectors++;
                    if (obs !== O_FLUSH) begin
                        miscompares++;
                        $display("FAIL linger_flush_t%0d_c%0d: got %b want %b", t, c, obs, O_FLUSH);
                    end
                    step();
                end
            end
        end
        vectors++;
        if (obs !== 5'b01101) begin
            miscompares++;
            $display("FAIL linger_expire: got %b want %b", obs, 5'b01101);
        end
        step();
        step();
        vectors++;
        if (obs !== 5'b11011) begin
            miscompares++;
            $display("FAIL linger_closed: got %b want %b", obs, 5'b11011);
        end
    endtask

    // Buffer empties on the same cycle as the expiring tick: no linger flag.
    task automatic test_linger_tie();
        test_reset();
        SND_BUFFER_EMPTY_i = 1'b0;
        REV_BUFFER_EMPTY_i = 1'b0;
        shut_tready_i = 1'b0;
        close_tvalid_i = 1'b1;
        close_tlast_i = 1'b1;
        step();
        close_tvalid_i = 1'b0;
        close_tlast_i = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick_i = 1'b1;
            step();
            tick_i = 1'b0;
            step();
        end
        vectors++;
        if (obs !== O_FLUSH) begin
            miscompares++;
            $display("FAIL tie_pre: got %b want %b", obs, O_FLUSH);
        end
        tick_i = 1'b1;
        SND_BUFFER_EMPTY_i = 1'b1;
        step();
        tick_i = 1'b0;
        vectors++;
        if (obs !== O_SEND) begin
            miscompares++;
            $display("FAIL tie_empty_wins: got %b want %b", obs, O_SEND);
        end
    endtask
`else
    // Without the linger timer, ticks never end the drain.
    task automatic test_no_linger();
        test_reset();
        SND_BUFFER_EMPTY_i = 1'b0;
        REV_BUFFER_EMPTY_i = 1'b1;
        shut_tready_i = 1'b0;
        close_tvalid_i = 1'b1;
        close_tlast_i = 1'b1;
        step();
        close_tvalid_i = 1'b0;
        close_tlast_i = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick_i = 1'b1;
            step();
            tick_i = 1'b0;
            step();
            vectors++;
            if (obs !== O_FLUSH) begin
                miscompares++;
                $display("FAIL nolinger_flush_t%0d: got %b want %b", t, obs, O_FLUSH);
            end
        end
        SND_BUFFER_EMPTY_i = 1'b1;
        tick_i = 1'b1;
        step();
        tick_i = 1'b0;
        vectors++;
        if (obs !== O_SEND) begin
            miscompares++;
            $display("FAIL nolinger_empty_exit: got %b want %b", obs, O_SEND);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_multi_beat_stall();
`ifdef UDT_CLOSE_LINGER_EN
        test_linger_timeout();
        test_linger_tie();
`else
        test_no_linger();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
